// File: rtl/fpu_mc.sv
// Multi-cycle single-precision FPU: one request in flight, per-opcode latency,
// valid/ready handshakes on both sides. Denormal operands/results flush to zero.
module fpu_mc #(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 8,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [31:0]      src1,
    input  logic [31:0]      src2,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             ovf,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int L_ADD = (LAT_ADD < 1) ? 1 : LAT_ADD;
    localparam int L_MUL = (LAT_MUL < 1) ? 1 : LAT_MUL;
    localparam int L_DIV = (LAT_DIV < 1) ? 1 : LAT_DIV;
    localparam int L_AM  = (L_ADD > L_MUL) ? L_ADD : L_MUL;
    localparam int L_MAX = (L_AM > L_DIV) ? L_AM : L_DIV;
    localparam int CNT_W = (L_MAX > 1) ? $clog2(L_MAX) : 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         op_q;
    logic [31:0]        src1_q;
    logic [31:0]        src2_q;
    logic [TAG_W-1:0]   tag_q;

    logic [3:0]         cur_op;
    logic [31:0]        cur_a;
    logic [31:0]        cur_b;
    logic [TAG_W-1:0]   cur_tag;
    logic [31:0]        res_c;
    logic               ovf_c;
    logic               ill_c;
    int                 lat_in;

    function automatic int lat_of(input logic [3:0] o);
        case (o)
            4'd0, 4'd1: return L_ADD;
            4'd2:       return L_MUL;
            4'd3:       return L_DIV;
            default:    return 1;
        endcase
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_tiny(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    // sig carries the leading one at bit 26 and guard/round/sticky in bits 2..0;
    // returns {overflow, packed result} after round-to-nearest-even.
    function automatic logic [32:0] round_pack(input logic s, input int ex,
                                               input logic [26:0] sig);
        logic [24:0] mr;
        logic        up;
        int          e2;
        up = sig[2] & (sig[3] | sig[1] | sig[0]);
        mr = {1'b0, sig[26:3]} + {24'd0, up};
        e2 = ex;
        if (mr[24]) begin
            mr = mr >> 1;
            e2 = ex + 1;
        end
        if (e2 >= 255)
            return {1'b1, s, 8'hFF, 23'd0};
        else if (e2 <= 0)
            return {1'b0, s, 31'd0};
        else
            return {1'b0, s, e2[7:0], mr[22:0]};
    endfunction

    function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [26:0] mx;
        logic [26:0] my;
        logic [26:0] msh;
        logic [27:0] sum;
        logic [26:0] dif;
        int          d;
        int          ex;
        int          lz;
        if (is_nan(a) || is_nan(b))
            return {1'b0, QNAN};
        if (is_inf(a) && is_inf(b))
            return (a[31] == b[31]) ? {1'b0, a} : {1'b0, QNAN};
        if (is_inf(a))
            return {1'b0, a};
        if (is_inf(b))
            return {1'b0, b};
        if (is_tiny(a) && is_tiny(b))
            return {1'b0, a[31] & b[31], 31'd0};
        if (is_tiny(a))
            return {1'b0, b};
        if (is_tiny(b))
            return {1'b0, a};
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d  = int'(x[30:23]) - int'(y[30:23]);
        ex = int'(x[30:23]);
        if (d > 26) begin
            msh = 27'd1;
        end else begin
            msh    = my >> d;
            msh[0] = msh[0] | (|(my & ((27'd1 << d) - 27'd1)));
        end
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, msh};
            if (sum[27])
                return round_pack(x[31], ex + 1, {sum[27:2], sum[1] | sum[0]});
            return round_pack(x[31], ex, sum[26:0]);
        end
        dif = mx - msh;
        if (dif == 27'd0)
            return 33'd0;
        lz = 0;
        for (int i = 0; i < 27; i++)
            if (dif[i])
                lz = 26 - i;
        return round_pack(x[31], ex - lz, dif << lz);
    endfunction

    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        int          ex;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_tiny(b)) || (is_inf(b) && is_tiny(a)))
            return {1'b0, QNAN};
        if (is_inf(a) || is_inf(b))
            return {1'b0, s, 8'hFF, 23'd0};
        if (is_tiny(a) || is_tiny(b))
            return {1'b0, s, 31'd0};
        p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        ex = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47])
            return round_pack(s, ex + 1, {p[47:22], |p[21:0]});
        return round_pack(s, ex, {p[46:21], |p[20:0]});
    endfunction

    // Restoring division: q[27] weighs 2^0, each later bit halves.
    function automatic logic [32:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [25:0] rem;
        logic [25:0] dv;
        logic [27:0] q;
        int          ex;
        s = a[31] ^ b[31];
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b)) || (is_tiny(a) && is_tiny(b)))
            return {1'b0, QNAN};
        if (is_inf(a) || is_tiny(b))
            return {1'b0, s, 8'hFF, 23'd0};
        if (is_inf(b) || is_tiny(a))
            return {1'b0, s, 31'd0};
        rem = {2'b00, 1'b1, a[22:0]};
        dv  = {2'b00, 1'b1, b[22:0]};
        q   = '0;
        for (int i = 27; i >= 0; i--) begin
            if (rem >= dv) begin
                q[i] = 1'b1;
                rem  = rem - dv;
            end
            rem = rem << 1;
        end
        ex = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[27])
            return round_pack(s, ex, {q[27:2], q[1] | q[0] | (rem != 26'd0)});
        return round_pack(s, ex - 1, {q[26:1], q[0] | (rem != 26'd0)});
    endfunction

    function automatic logic f_eq(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b))
            return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
            return 1'b1;
        return a == b;
    endfunction

    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b))
            return 1'b0;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
            return 1'b0;
        if (a[31] != b[31])
            return a[31];
        if (!a[31])
            return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    // On the accept cycle the live inputs feed the datapath so 1-cycle ops can
    // be captured at the accept edge; afterwards only the registered copies do.
    assign cur_op  = (state == IDLE) ? op   : op_q;
    assign cur_a   = (state == IDLE) ? src1 : src1_q;
    assign cur_b   = (state == IDLE) ? src2 : src2_q;
    assign cur_tag = (state == IDLE) ? tag  : tag_q;

    assign lat_in    = lat_of(op);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        res_c = '0;
        ovf_c = 1'b0;
        ill_c = 1'b0;
        case (cur_op)
            4'd0: {ovf_c, res_c} = fadd(cur_a, cur_b);
            4'd1: {ovf_c, res_c} = fadd(cur_a, {~cur_b[31], cur_b[30:0]});
            4'd2: {ovf_c, res_c} = fmul(cur_a, cur_b);
            4'd3: {ovf_c, res_c} = fdiv(cur_a, cur_b);
            4'd4: res_c = {31'd0, f_eq(cur_a, cur_b)};
            4'd5: res_c = {31'd0, f_lt(cur_a, cur_b)};
            4'd6: res_c = {31'd0, f_lt(cur_a, cur_b) | f_eq(cur_a, cur_b)};
            4'd7, 4'd8: begin
                if (is_nan(cur_a) && is_nan(cur_b))
                    res_c = QNAN;
                else if (is_nan(cur_a))
                    res_c = cur_b;
                else if (is_nan(cur_b))
                    res_c = cur_a;
                else if (cur_a[30:0] == 31'd0 && cur_b[30:0] == 31'd0)
                    res_c = (cur_op == 4'd7) ? {cur_a[31] | cur_b[31], 31'd0}
                                             : {cur_a[31] & cur_b[31], 31'd0};
                else if (f_lt(cur_a, cur_b) == (cur_op == 4'd7))
                    res_c = cur_a;
                else
                    res_c = cur_b;
            end
            4'd9:  res_c = {cur_b[31], cur_a[30:0]};
            4'd10: res_c = {~cur_b[31], cur_a[30:0]};
            4'd11: res_c = {cur_a[31] ^ cur_b[31], cur_a[30:0]};
            default: ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            tag_q   <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
            out_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        src1_q <= src1;
                        src2_q <= src2;
                        tag_q  <= tag;
                        cnt    <= CNT_W'(lat_in - 1);
                        if (lat_in == 1) begin
                            state   <= DONE;
                            result  <= res_c;
                            ovf     <= ovf_c;
                            illegal <= ill_c;
                            out_tag <= cur_tag;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        result  <= res_c;
                        ovf     <= ovf_c;
                        illegal <= ill_c;
                        out_tag <= cur_tag;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mc.sv
// Bench for fpu_mc: directed vectors plus random requests checked against a
// model that evaluates the operations with real arithmetic.
module tb_fpu_mc;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;
    logic        illegal;
    logic [4:0]  out_tag;
    logic        busy;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    fpu_mc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .illegal   (illegal),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        real         r;
        if (x[30:23] == 8'h00) begin
            r = real'(x[22:0]) * (2.0 ** -149);
            return x[31] ? -r : r;
        end
        d = {x[31], (x[30:23] == 8'hFF) ? 11'h7FF : 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round a double to single precision (nearest-even); {overflow, bits}.
    function automatic logic [32:0] from_real(input real r);
        logic [63:0] d;
        logic [24:0] m;
        logic        up;
        int          ex;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF)
            return (d[51:0] != 52'd0) ? {1'b0, QNAN} : {1'b0, d[63], 8'hFF, 23'd0};
        ex = int'(d[62:52]) - 896;
        if (ex <= 0)
            return {1'b0, d[63], 31'd0};
        up = d[28] & ((|d[27:0]) | d[29]);
        m  = {2'b01, d[51:29]} + 25'(up);
        if (m[24])
            ex++;
        if (ex >= 255)
            return {1'b1, d[63], 8'hFF, 23'd0};
        return {1'b0, d[63], 8'(ex), m[22:0]};
    endfunction

    // Returns {illegal, ovf, result}.
    function automatic logic [33:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        real ra;
        real rb;
        logic anyn;
        ra   = to_real(a);
        rb   = to_real(b);
        anyn = is_nan(a) || is_nan(b);
        case (o)
            4'd0: return {1'b0, from_real(ra + rb)};
            4'd1: return {1'b0, from_real(ra - rb)};
            4'd2: return {1'b0, from_real(ra * rb)};
            4'd3: return {1'b0, from_real(ra / rb)};
            4'd4: return {2'b00, 31'd0, !anyn && (ra == rb)};
            4'd5: return {2'b00, 31'd0, !anyn && (ra < rb)};
            4'd6: return {2'b00, 31'd0, !anyn && (ra <= rb)};
            4'd7, 4'd8: begin
                if (is_nan(a) && is_nan(b)) return {2'b00, QNAN};
                if (is_nan(a)) return {2'b00, b};
                if (is_nan(b)) return {2'b00, a};
                if (ra == 0.0 && rb == 0.0)
                    return {2'b00, (o == 4'd7) ? (a[31] | b[31]) : (a[31] & b[31]), 31'd0};
                if (o == 4'd7) return {2'b00, (ra < rb) ? a : b};
                return {2'b00, (ra > rb) ? a : b};
            end
            4'd9:  return {2'b00, b[31], a[30:0]};
            4'd10: return {2'b00, ~b[31], a[30:0]};
            4'd11: return {2'b00, a[31] ^ b[31], a[30:0]};
            default: return {1'b1, 1'b0, 32'd0};
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] o);
        if (o <= 4'd1) return 1;
        if (o == 4'd2) return 2;
        if (o == 4'd3) return 8;
        return 1;
    endfunction

    function automatic logic [31:0] rnd_norm(input int lo, input int hi);
        return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_any(input logic [31:0] other);
        case ($urandom_range(7, 0))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return QNAN;
            3: return 32'hFF80_0123;
            4: return other;
            5: return {~other[31], other[30:0]};
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] t, input int hold);
        logic [33:0] want;
        int          cyc;
        want = model(o, a, b);
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = o;
        src1      = a;
        src2      = b;
        tag       = t;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        src1     = $urandom;
        src2     = $urandom;
        tag      = 5'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 40);
        checkOutput("latency", 32'(cyc), 32'(exp_lat(o)));
        checkOutput("result", result, want[31:0]);
        checkOutput("ovf", 32'(ovf), 32'(want[32]));
        checkOutput("illegal", 32'(illegal), 32'(want[33]));
        checkOutput("out_tag", 32'(out_tag), 32'(t));
        last_result = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_result", result, want[31:0]);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
        checkOutput("post_hs_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        src1      = 32'd0;
        src2      = 32'd0;
        tag       = 5'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_illegal", 32'(illegal), 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;

        applyStimulus(4'd0, 32'h3F80_0000, 32'h4000_0000, 5'h0A, 0);
        checkOutput("add_const", last_result, 32'h4040_0000);
        applyStimulus(4'd3, 32'h40C0_0000, 32'h4000_0000, 5'h13, 5);
        checkOutput("div_const", last_result, 32'h4040_0000);
        applyStimulus(4'd4, 32'h0000_0000, 32'h8000_0000, 5'h01, 0);
        checkOutput("eq_zero", last_result, 32'd1);
        applyStimulus(4'd5, 32'h7FC0_0000, 32'h3F80_0000, 5'h02, 0);
        checkOutput("lt_nan", last_result, 32'd0);
        applyStimulus(4'd6, 32'hBF80_0000, 32'h3F80_0000, 5'h03, 1);
        checkOutput("le_neg", last_result, 32'd1);
        applyStimulus(4'd7, 32'h8000_0000, 32'h0000_0000, 5'h04, 0);
        checkOutput("min_zero", last_result, 32'h8000_0000);
        applyStimulus(4'd8, 32'h7FC0_0000, 32'h4000_0000, 5'h05, 0);
        checkOutput("max_nan", last_result, 32'h4000_0000);
        applyStimulus(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'h06, 0);
        checkOutput("illegal_res", last_result, 32'd0);
        applyStimulus(4'd2, 32'h7F00_0000, 32'h7F00_0000, 5'h07, 0);
        checkOutput("mul_ovf", last_result, 32'h7F80_0000);
        applyStimulus(4'd1, 32'h4040_0000, 32'h4040_0000, 5'h08, 0);
        checkOutput("sub_zero", last_result, 32'h0000_0000);

        // Abort a divide partway through; its result must never surface.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'd3;
        src1     = 32'h40C0_0000;
        src2     = 32'h4000_0000;
        tag      = 5'h1F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_result", result, 32'd0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("abort_no_result", 32'(seen), 32'd0);
        applyStimulus(4'd0, 32'h3F80_0000, 32'h4000_0000, 5'h0B, 0);

        // Reset in DONE wins over a simultaneous output handshake, and reset in
        // IDLE wins over a simultaneous request.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 4'd2;
        src1     = 32'h4000_0000;
        src2     = 32'h4000_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        checkOutput("done_reached", 32'(out_valid), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        checkOutput("rst_done_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_done_result", result, 32'd0);
        @(negedge clk);
        checkOutput("rst_over_accept", 32'(busy), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        for (int n = 0; n < 80; n++) begin
            o = 4'($urandom_range(15, 0));
            if (o <= 4'd3) begin
                if (o == 4'd2 && $urandom_range(5, 0) == 0) begin
                    a = rnd_norm(230, 254);
                    b = rnd_norm(230, 254);
                end else begin
                    a = rnd_norm(100, 154);
                    b = rnd_norm(100, 154);
                end
            end else begin
                a = $urandom;
                b = rnd_any(a);
                if ($urandom_range(3, 0) == 0) a = rnd_any(b);
            end
            applyStimulus(o, a, b, 5'($urandom), $urandom_range(2, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_mc.md
FPU_MC -- requirements
Module: fpu_mc

Interface
REQ-001 Parameter: LAT_ADD, default 1, accept-to-out_valid cycles for add/sub.
REQ-002 Parameter: LAT_MUL, default 2, accept-to-out_valid cycles for mul.
REQ-003 Parameter: LAT_DIV, default 8, accept-to-out_valid cycles for div.
REQ-004 Parameter: TAG_W, default 5, width of the request tag carried to the output.
REQ-005 Port: clk, input, 1, sole clock; all state updates on rising edge.
REQ-006 Port: rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-007 Port: in_valid, input, 1, request present.
REQ-008 Port: in_ready, output, 1, block can accept a request.
REQ-009 Port: op, input, 4, opcode: 0 add, 1 sub, 2 mul, 3 div, 4 eq, 5 lt, 6 le, 7 min, 8 max, 9 sgnj, 10 sgnjn, 11 sgnjx, 12-15 illegal.
REQ-010 Port: src1 / src2, input, 32 each, IEEE-754 single operands.
REQ-011 Port: tag, input, TAG_W, opaque request id.
REQ-012 Port: out_valid, output, 1, result present.
REQ-013 Port: out_ready, input, 1, consumer accepts result.
REQ-014 Port: result, output, 32, operation result.
REQ-015 Port: ovf / illegal, output, 1 each, overflow flag; unsupported-opcode flag.
REQ-016 Port: out_tag, output, TAG_W, tag of the request that produced result.
REQ-017 Port: busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, EXEC, DONE; in_ready = (state==IDLE) only; no accept in the same cycle as an output handshake.
REQ-019 Accept = in_valid & in_ready; op, src1, src2 and tag are registered on accept, and input changes afterwards have no effect.
REQ-020 Latency L: add/sub LAT_ADD, mul LAT_MUL, div LAT_DIV, all other opcodes (including illegal) 1; a LAT_* value of 0 is treated as 1.
REQ-021 On accept, a counter is loaded with L-1; state goes to DONE if L-1==0, else EXEC; EXEC decrements each cycle and goes to DONE when the count reaches 0.
REQ-022 out_valid rises exactly L cycles after the accept edge.
REQ-023 Entry to DONE registers result, ovf, illegal and out_tag.
REQ-024 add/sub/mul/div results and ovf come from the existing fadd/fsub/fmul/fdiv units, fed by the registered operands.
REQ-025 eq/lt/le return {31'b0, bit}; any NaN operand (exp 0xFF, mantissa nonzero) yields 0; +0 and -0 compare equal; ordering is by sign-magnitude.
REQ-026 min/max: if one operand is NaN, return the other; if both are NaN, return 0x7FC00000; min(-0,+0) = 0x80000000; max(-0,+0) = 0x00000000.
REQ-027 sgnj/sgnjn/sgnjx return src1[30:0] with sign src2[31], ~src2[31], or src1[31]^src2[31] respectively.
REQ-028 ovf = 0 for every non-arithmetic opcode.
REQ-029 Illegal opcode: result 0, ovf 0, illegal 1.
REQ-030 In DONE, out_valid=1 and result/ovf/illegal/out_tag stay stable until out_valid & out_ready; that handshake returns the state to IDLE.
REQ-031 Outside DONE, out_valid=0; result/flag values are then don't-care but must not change while out_valid=1.

Reset
REQ-032 rst sampled high forces IDLE on that edge: out_valid 0, in_ready 1, busy 0, result 0, ovf 0, illegal 0, out_tag 0, counter 0.
REQ-033 rst during EXEC or DONE aborts the operation; no result for it is ever presented; rst overrides a simultaneous accept or output handshake.

Verification
REQ-034 Add: src1 0x3F800000, src2 0x40000000, LAT_ADD=1 -> out_valid one cycle after accept, result 0x40400000, ovf 0, tag echoed.
REQ-035 Div: 0x40C00000 / 0x40000000 with LAT_DIV=8 and out_ready low for 5 cycles -> out_valid at cycle 8; result 0x40400000 held stable; in_ready 0 until the handshake, 1 the cycle after.
REQ-036 Compare: eq(0x00000000, 0x80000000) -> 1; lt(0x7FC00000, 0x3F800000) -> 0; le(0xBF800000, 0x3F800000) -> 1.
REQ-037 min/max: min(0x80000000, 0x00000000) -> 0x80000000; max(0x7FC00000, 0x40000000) -> 0x40000000.
REQ-038 Illegal: op 15 -> out_valid after 1 cycle, result 0, illegal 1.
REQ-039 Reset mid-div at cycle 3 -> next cycle out_valid 0, in_ready 1, busy 0; a following add completes normally.
